// File: rtl/jpeg_coef_blkbuf.sv
// rtl/jpeg_coef_blkbuf.sv - ping-pong coefficient block buffer between Huffman decode and IDCT
// Optional JPEG_BLKBUF_DEZIGZAG_EN: write address is dezigzag(idx); otherwise idx is used as-is.
module jpeg_coef_blkbuf #(
  parameter int ID_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            img_start_i,
  input  logic            inport_valid_i,
  input  logic [15:0]     inport_data_i,
  input  logic [5:0]      inport_idx_i,
  input  logic [ID_W-1:0] inport_id_i,
  input  logic            inport_eob_i,
  output logic            inport_blk_space_o,
  output logic            outport_valid_o,
  output logic [15:0]     outport_data_o,
  output logic [5:0]      outport_idx_o,
  output logic [ID_W-1:0] outport_id_o,
  output logic            outport_last_o,
  input  logic            outport_accept_i
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  logic [15:0]     r_mem  [2][64];
  logic [63:0]     r_bmap [2];
  logic [ID_W-1:0] r_id   [2];
  logic [1:0]      r_full;
  logic            r_wr_sel;
  logic            r_rd_sel;
  logic            r_eob_prev;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [5:0]      r_beat;
  logic [5:0]      w_beat_nxt;
  logic            w_wr_en;
  logic            w_commit;
  logic            w_drain;
  logic            w_streaming;
  logic [5:0]      w_wr_addr;

`ifdef JPEG_BLKBUF_DEZIGZAG_EN
  localparam logic [5:0] ZZ2NAT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  assign w_wr_addr = ZZ2NAT[inport_idx_i];
`else
  assign w_wr_addr = inport_idx_i;
`endif

  // A full write buffer swallows both data and a stray commit until the reader frees it.
  assign w_wr_en  = inport_valid_i && !r_full[r_wr_sel] && !img_start_i;
  assign w_commit = inport_eob_i && !r_eob_prev && !r_full[r_wr_sel] && !img_start_i;

  // Data RAM needs no reset: the written-bitmap decides whether an entry is meaningful.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_sel][w_wr_addr] <= inport_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_full     <= 2'b00;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_eob_prev <= 1'b0;
      r_bmap[0]  <= '0;
      r_bmap[1]  <= '0;
      r_id[0]    <= '0;
      r_id[1]    <= '0;
    end else if (img_start_i) begin
      r_full     <= 2'b00;
      r_wr_sel   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_eob_prev <= 1'b0;
      r_bmap[0]  <= '0;
      r_bmap[1]  <= '0;
      r_id[0]    <= '0;
      r_id[1]    <= '0;
    end else begin
      r_eob_prev <= inport_eob_i;
      if (w_wr_en) begin
        r_bmap[r_wr_sel][w_wr_addr] <= 1'b1;
      end
      if (w_commit) begin
        r_full[r_wr_sel] <= 1'b1;
        r_id[r_wr_sel]   <= inport_id_i;
        r_wr_sel         <= ~r_wr_sel;
      end
      // Drain targets a full buffer, writes a non-full one, so these never collide.
      if (w_drain) begin
        r_full[r_rd_sel] <= 1'b0;
        r_bmap[r_rd_sel] <= '0;
        r_rd_sel         <= ~r_rd_sel;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
    end else if (img_start_i) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_drain     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_sel]) begin
          w_state_nxt = ST_STREAM;
          w_beat_nxt  = '0;
        end
      end
      ST_STREAM: begin
        if (outport_accept_i) begin
          if (r_beat == 6'd63) begin
            w_drain     = 1'b1;
            w_state_nxt = ST_IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat + 6'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  assign w_streaming        = (r_state == ST_STREAM);
  assign outport_valid_o    = w_streaming;
  assign outport_data_o     = (w_streaming && r_bmap[r_rd_sel][r_beat]) ? r_mem[r_rd_sel][r_beat] : 16'd0;
  assign outport_idx_o      = w_streaming ? r_beat : 6'd0;
  assign outport_id_o       = w_streaming ? r_id[r_rd_sel] : '0;
  assign outport_last_o     = w_streaming && (r_beat == 6'd63);
  assign inport_blk_space_o = !r_full[r_wr_sel];

endmodule

// File: tb/tb_jpeg_coef_blkbuf.sv
// tb/tb_jpeg_coef_blkbuf.sv - directed self-checking bench for jpeg_coef_blkbuf
module tb_jpeg_coef_blkbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        img_start;
  logic        in_valid;
  logic [15:0] in_data;
  logic [5:0]  in_idx;
  logic [31:0] in_id;
  logic        in_eob;
  logic        blk_space;
  logic        out_valid;
  logic [15:0] out_data;
  logic [5:0]  out_idx;
  logic [31:0] out_id;
  logic        out_last;
  logic        accept;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_data [64];
  logic [15:0] blk_data [64];
  logic [31:0] blk_id;

`ifdef JPEG_BLKBUF_DEZIGZAG_EN
  localparam int ZZ_TAB [64] = '{
    0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
  function automatic int zz(input int i);
    return ZZ_TAB[i];
  endfunction
`else
  function automatic int zz(input int i);
    return i;
  endfunction
`endif

  jpeg_coef_blkbuf #(.ID_W(32)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .img_start_i        (img_start),
    .inport_valid_i     (in_valid),
    .inport_data_i      (in_data),
    .inport_idx_i       (in_idx),
    .inport_id_i        (in_id),
    .inport_eob_i       (in_eob),
    .inport_blk_space_o (blk_space),
    .outport_valid_o    (out_valid),
    .outport_data_o     (out_data),
    .outport_idx_o      (out_idx),
    .outport_id_o       (out_id),
    .outport_last_o     (out_last),
    .outport_accept_i   (accept)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic wr(input int idx, input logic [15:0] d);
    in_valid = 1'b1;
    in_idx   = 6'(idx);
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic commit(input logic [31:0] id);
    in_eob = 1'b1;
    in_id  = id;
    tick();
    in_eob = 1'b0;
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 64; i++) exp_data[i] = 16'h0000;
  endtask

  task automatic set_exp(input int zzidx, input logic [15:0] v);
    exp_data[zz(zzidx)] = v;
  endtask

  // pat 0: accept held high; pat 1: accept follows 1,0,0,1 per presented beat
  task automatic get_block(input string tag, input int pat);
    int n = 0;
    int cyc = 0;
    int ph = 0;
    int seq_err = 0;
    int stab_err = 0;
    logic held = 1'b0;
    logic acc;
    logic [15:0] hd = '0;
    logic [5:0] hi = '0;
    for (int i = 0; i < 64; i++) blk_data[i] = 16'hxxxx;
    while (n < 64 && cyc < 400) begin
      acc = (pat == 0) ? 1'b1 : ((ph % 4 == 0) || (ph % 4 == 3));
      accept = acc;
      if (out_valid) begin
        if (held && (out_data !== hd || out_idx !== hi)) stab_err++;
        if (acc) begin
          if (out_idx !== 6'(n)) seq_err++;
          if (out_last !== (n == 63)) seq_err++;
          blk_data[out_idx] = out_data;
          blk_id = out_id;
          n++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd = out_data;
          hi = out_idx;
        end
        ph++;
      end
      tick();
      cyc++;
    end
    accept = 1'b0;
    chk({tag, "_beats"}, 32'(n), 32'd64);
    chk({tag, "_seq"}, 32'(seq_err), 32'd0);
    chk({tag, "_stable"}, 32'(stab_err), 32'd0);
  endtask

  task automatic chk_blk(input string tag, input logic [31:0] exp_id);
    int mism = 0;
    for (int i = 0; i < 64; i++) if (blk_data[i] !== exp_data[i]) mism++;
    chk({tag, "_data"}, 32'(mism), 32'd0);
    chk({tag, "_id"}, blk_id, exp_id);
  endtask

  initial begin
    int cnt;
    int cyc;
    rst = 1'b1; img_start = 1'b0; in_valid = 1'b0; in_data = '0; in_idx = '0;
    in_id = '0; in_eob = 1'b0; accept = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_space", 32'(blk_space), 32'd1);
    rst = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_data", 32'(out_data), 32'd0);
    chk("idle_idx", 32'(out_idx), 32'd0);
    chk("idle_id", out_id, 32'd0);
    chk("idle_last", 32'(out_last), 32'd0);
    chk("idle_space", 32'(blk_space), 32'd1);

    // basic block with latency check
    wr(0, 16'h0010); wr(2, 16'hFFFE); wr(5, 16'h0003);
    commit(32'h7);
    chk("lat_c1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c2", 32'(out_valid), 32'd1);
    chk("lat_space", 32'(blk_space), 32'd1);
    clr_exp(); set_exp(0, 16'h0010); set_exp(2, 16'hFFFE); set_exp(5, 16'h0003);
    get_block("basic", 0);
    chk_blk("basic", 32'h7);
`ifdef JPEG_BLKBUF_DEZIGZAG_EN
    chk("dz_idx2", 32'(blk_data[2]), 32'h0003);
    chk("dz_idx8", 32'(blk_data[8]), 32'hFFFE);
`endif

    // back-pressure: two blocks pending, third-block writes dropped
    wr(1, 16'h0AAA); commit(32'hA);
    wr(3, 16'h0BBB); commit(32'hB);
    tick();
    chk("bp_space0", 32'(blk_space), 32'd0);
    wr(4, 16'h1234); wr(0, 16'h1234);
    clr_exp(); set_exp(1, 16'h0AAA);
    get_block("bpA", 0);
    chk("bp_space1", 32'(blk_space), 32'd1);
    chk_blk("bpA", 32'hA);
    clr_exp(); set_exp(3, 16'h0BBB);
    get_block("bpB", 0);
    chk_blk("bpB", 32'hB);

    // eob held five cycles commits once
    wr(7, 16'h0077);
    in_eob = 1'b1; in_id = 32'h55;
    for (int i = 0; i < 5; i++) tick();
    in_eob = 1'b0;
    clr_exp(); set_exp(7, 16'h0077);
    get_block("eobh", 0);
    chk_blk("eobh", 32'h55);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) cnt++;
      tick();
    end
    chk("eobh_single", 32'(cnt), 32'd0);

    // write and eob in the same cycle
    in_valid = 1'b1; in_idx = 6'd63; in_data = 16'h0042; in_eob = 1'b1; in_id = 32'h63;
    tick();
    in_valid = 1'b0; in_eob = 1'b0;
    clr_exp(); set_exp(63, 16'h0042);
    get_block("same", 0);
    chk_blk("same", 32'h63);
    chk("same_b63", 32'(blk_data[63]), 32'h0042);

    // accept stalls 1,0,0,1
    wr(10, 16'h0101); wr(20, 16'h0202);
    commit(32'h99);
    clr_exp(); set_exp(10, 16'h0101); set_exp(20, 16'h0202);
    get_block("stall", 1);
    chk_blk("stall", 32'h99);

    // img_start aborts mid-stream with the other buffer full
    wr(1, 16'h1111); commit(32'h21);
    wr(2, 16'h2222); commit(32'h22);
    accept = 1'b1;
    cnt = 0; cyc = 0;
    while (cnt < 20 && cyc < 100) begin
      if (out_valid) cnt++;
      tick();
      cyc++;
    end
    accept = 1'b0;
    chk("abort_beat", 32'(out_idx), 32'd20);
    img_start = 1'b1;
    tick();
    img_start = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_space", 32'(blk_space), 32'd1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) cnt++;
      tick();
    end
    chk("abort_empty", 32'(cnt), 32'd0);
    wr(4, 16'h4444); commit(32'h44);
    clr_exp(); set_exp(4, 16'h4444);
    get_block("post", 0);
    chk_blk("post", 32'h44);

    // asynchronous reset during streaming
    wr(0, 16'h5555); commit(32'h66);
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("ar_pre", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data", 32'(out_data), 32'd0);
    chk("ar_id", out_id, 32'd0);
    chk("ar_space", 32'(blk_space), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_after", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
